// File: rtl/encoder4to2_seq.sv
// Sequential 4-to-2 encoder: captures one-hot request pulses as pending lines and
// serializes them as 2-bit codes on a valid/ready output, fixed-priority or round-robin.
module encoder4to2_seq #(
  parameter bit RR = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din,
  input  logic       en,
  output logic [1:0] dout,
  output logic       valid,
  input  logic       ready,
  output logic       merge,
  output logic       busy
);

  localparam int unsigned N_LINES = 4;
  localparam int unsigned IDX_W   = 2;

  logic [N_LINES-1:0] r_pending;
  logic [IDX_W-1:0]   r_last;

  logic               w_load;
  logic               w_found;
  logic [IDX_W-1:0]   w_base;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_code;
  logic [N_LINES-1:0] w_req;
  logic [N_LINES-1:0] w_clr;
  logic [N_LINES-1:0] w_pending_nxt;
  logic               w_merge_nxt;

  // Fixed priority is a round-robin scan that always starts after line 3.
  always_comb begin
    w_base  = RR ? r_last : IDX_W'(N_LINES - 1);
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= int'(N_LINES); k++) begin
      w_idx = IDX_W'(w_base + IDX_W'(k));
      if (!w_found && r_pending[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_load        = (!valid || ready) && (|r_pending);
  assign w_req         = din & {N_LINES{en}};
  assign w_clr         = w_load ? (N_LINES'(1) << w_sel) : '0;
  assign w_pending_nxt = (r_pending & ~w_clr) | w_req;
  assign w_merge_nxt   = |(w_req & r_pending & ~w_clr);
  // Bit-swapped index so the 2-to-4 decoder regenerates the original line.
  assign w_code        = {w_sel[0], w_sel[1]};
  assign busy          = (|r_pending) | valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_last    <= IDX_W'(N_LINES - 1);
      dout      <= '0;
      valid     <= 1'b0;
      merge     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      merge     <= w_merge_nxt;
      if (w_load) begin
        dout  <= w_code;
        valid <= 1'b1;
        if (RR) begin
          r_last <= w_sel;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encoder4to2_seq.sv
// Bench for encoder4to2_seq: directed vector table, fairness/reset sequences and
// randomized traffic, with both arbitration modes checked against a reference model.
module tb_encoder4to2_seq;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       en;
  logic       ready;
  logic [1:0] dout0, dout1;
  logic       valid0, valid1, merge0, merge1, busy0, busy1;

  always #5 clk = ~clk;

  encoder4to2_seq #(.RR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .dout(dout0),
    .valid(valid0), .ready(ready), .merge(merge0), .busy(busy0)
  );

  encoder4to2_seq #(.RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .dout(dout1),
    .valid(valid1), .ready(ready), .merge(merge1), .busy(busy1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per instance, a set of pending lines and the presented line.
  bit mp    [2][4];
  bit mv    [2];
  int mline [2];
  int mlast [2];
  bit mm    [2];
  int code_of [4] = '{0, 2, 1, 3};

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int n = 0; n < 2; n++) begin
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) mp[n][i] = 1'b0;
        mv[n] = 1'b0; mline[n] = 0; mlast[n] = 3; mm[n] = 1'b0;
      end else begin
        int  sel;
        int  start;
        bit  any;
        bit  newm;
        bit  req;
        sel = -1;
        any = 1'b0;
        for (int i = 0; i < 4; i++) any |= mp[n][i];
        if ((!mv[n] || ready) && any) begin
          start = (n == 1) ? mlast[n] : 3;
          for (int k = 1; k <= 4; k++)
            if (sel < 0 && mp[n][(start + k) % 4]) sel = (start + k) % 4;
        end
        newm = 1'b0;
        for (int i = 0; i < 4; i++) begin
          req = din[i] && en;
          if (req && mp[n][i] && i != sel) newm = 1'b1;
          mp[n][i] = (i == sel) ? req : (mp[n][i] | req);
        end
        if (sel >= 0) begin
          mv[n] = 1'b1; mline[n] = sel;
          if (n == 1) mlast[n] = sel;
        end else if (mv[n] && ready) begin
          mv[n] = 1'b0;
        end
        mm[n] = newm;
      end
    end
  endtask

  task automatic check_model();
    for (int n = 0; n < 2; n++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < 4; i++) any |= mp[n][i];
      check($sformatf("model%0d valid", n), int'(n ? valid1 : valid0), int'(mv[n]));
      check($sformatf("model%0d dout", n), int'(n ? dout1 : dout0), code_of[mline[n]]);
      check($sformatf("model%0d merge", n), int'(n ? merge1 : merge0), int'(mm[n]));
      check($sformatf("model%0d busy", n), int'(n ? busy1 : busy0), int'(any | mv[n]));
    end
  endtask

  task automatic step(input logic [3:0] d, input logic e, input logic r, input logic rs);
    din = d; en = e; ready = r; rst_n = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [3:0] din;
    logic       en;
    logic       ready;
    logic       rst_n;
    logic       v;
    logic [1:0] d;
    logic       m;
    logic       b;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] d, input logic e, input logic r,
                              input logic rs, input logic v, input logic [1:0] dd,
                              input logic m, input logic b);
    vec_t t;
    t.din = d; t.en = e; t.ready = r; t.rst_n = rs;
    t.v = v; t.d = dd; t.m = m; t.b = b;
    return t;
  endfunction

  vec_t tbl [27];

  initial begin
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 4; i++) mp[n][i] = 1'b0;
      mv[n] = 1'b0; mline[n] = 0; mlast[n] = 3; mm[n] = 1'b0;
    end
    din = 4'hF; en = 1'b1; ready = 1'b1; rst_n = 1'b0;

    // Expected outputs of the fixed-priority instance after each row's edge.
    tbl[0]  = mk(4'hF,    H, H, L, L, 2'b00, L, L);
    tbl[1]  = mk(4'hF,    H, H, L, L, 2'b00, L, L);
    tbl[2]  = mk(4'h0,    H, H, H, L, 2'b00, L, L);
    tbl[3]  = mk(4'h0,    H, H, H, L, 2'b00, L, L);
    tbl[4]  = mk(4'b0100, H, H, H, L, 2'b00, L, H);
    tbl[5]  = mk(4'h0,    H, H, H, H, 2'b01, L, H);
    tbl[6]  = mk(4'h0,    H, H, H, L, 2'b01, L, L);
    tbl[7]  = mk(4'hF,    H, H, H, L, 2'b01, L, H);
    tbl[8]  = mk(4'h0,    H, H, H, H, 2'b00, L, H);
    tbl[9]  = mk(4'h0,    H, H, H, H, 2'b10, L, H);
    tbl[10] = mk(4'h0,    H, H, H, H, 2'b01, L, H);
    tbl[11] = mk(4'h0,    H, H, H, H, 2'b11, L, H);
    tbl[12] = mk(4'h0,    H, H, H, L, 2'b11, L, L);
    tbl[13] = mk(4'b0010, H, L, H, L, 2'b11, L, H);
    tbl[14] = mk(4'b0001, H, L, H, H, 2'b10, L, H);
    tbl[15] = mk(4'h0,    H, L, H, H, 2'b10, L, H);
    tbl[16] = mk(4'h0,    H, L, H, H, 2'b10, L, H);
    tbl[17] = mk(4'h0,    H, H, H, H, 2'b00, L, H);
    tbl[18] = mk(4'h0,    H, H, H, L, 2'b00, L, L);
    tbl[19] = mk(4'b1001, H, L, H, L, 2'b00, L, H);
    tbl[20] = mk(4'h0,    H, L, H, H, 2'b00, L, H);
    tbl[21] = mk(4'b1000, H, L, H, H, 2'b00, H, H);
    tbl[22] = mk(4'h0,    H, L, H, H, 2'b00, L, H);
    tbl[23] = mk(4'hF,    L, L, H, H, 2'b00, L, H);
    tbl[24] = mk(4'h0,    H, H, H, H, 2'b11, L, H);
    tbl[25] = mk(4'h0,    H, H, H, L, 2'b11, L, L);
    tbl[26] = mk(4'h0,    H, H, H, L, 2'b11, L, L);

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].din, tbl[i].en, tbl[i].ready, tbl[i].rst_n);
      check($sformatf("row%0d valid", i), int'(valid0), int'(tbl[i].v));
      check($sformatf("row%0d dout", i),  int'(dout0),  int'(tbl[i].d));
      check($sformatf("row%0d merge", i), int'(merge0), int'(tbl[i].m));
      check($sformatf("row%0d busy", i),  int'(busy0),  int'(tbl[i].b));
    end

    // Fairness under held requests on lines 0 and 1.
    step(4'h0, H, H, L);
    for (int k = 1; k <= 8; k++) begin
      step(4'b0011, H, H, H);
      if (k >= 2) begin
        check($sformatf("fair fp valid k%0d", k), int'(valid0), 1);
        check($sformatf("fair fp dout k%0d", k),  int'(dout0),  0);
        check($sformatf("fair rr valid k%0d", k), int'(valid1), 1);
        check($sformatf("fair rr dout k%0d", k),  int'(dout1),  (k % 2 == 0) ? 0 : 2);
      end
    end
    // Reset mid-stream drops everything.
    step(4'b0011, H, H, L);
    check("midrst fp valid", int'(valid0), 0);
    check("midrst rr valid", int'(valid1), 0);
    check("midrst fp busy",  int'(busy0),  0);
    check("midrst rr busy",  int'(busy1),  0);
    for (int k = 0; k < 3; k++) begin
      step(4'h0, H, H, H);
      check($sformatf("post-rst fp valid %0d", k), int'(valid0), 0);
      check($sformatf("post-rst rr valid %0d", k), int'(valid1), 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] d;
      d = 4'($urandom) & 4'($urandom);
      step(d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 99) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/encoder4to2_seq.md
Name: encoder4to2_seq

Overview:
- Sequential 4-to-2 encoder. It is the encode-side counterpart of the team's 2-to-4 decoder.
- Captures request pulses on four one-hot lines and holds them as pending bits.
- Serializes pending lines into 2-bit codes on a valid/ready output.
- Code mapping is chosen so that feeding dout into the 2-to-4 decoder (dout[0]->din[0], dout[1]->din[1]) regenerates the original line.

Parameters:
- RR, 0: arbitration mode. 0 = fixed priority, line 0 highest and line 3 lowest. 1 = round-robin.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- din  input  4  request lines; bit i high for one or more cycles requests line i
- en  input  1  capture enable; din is ignored when low
- dout  output  2  encoded line index, registered
- valid  output  1  dout holds a code
- ready  input  1  consumer accepts dout this cycle
- merge  output  1  one-cycle pulse: a request hit a line that was already pending
- busy  output  1  high when any line is pending or valid=1

Behaviour:
- Code map:
  - line 0 -> 2'b00
  - line 1 -> 2'b10
  - line 2 -> 2'b01
  - line 3 -> 2'b11
  - Formally, dout = {i[0], i[1]}.
- State:
  - pending[3:0]
  - output register {valid, dout}
  - RR pointer last[1:0]
  - merge register
- Reset (rst_n=0 at a clock edge):
  - pending=0, valid=0, dout=2'b00, merge=0, last=2'd3.
  - busy=0, since it is derived from pending and valid.
  - Reset overrides all other inputs. Reset mid-transfer drops every pending line and the in-flight code, with no partial output.
- Load condition: load = (valid==0 || ready==1) && |pending.
- On load:
  - Select line s from the registered pending bits.
  - dout <= code(s); valid <= 1.
  - Clear pending[s]; if RR=1, last <= s.
- If valid && ready && no pending line: valid <= 0. dout keeps its last value.
- While valid && !ready: dout and valid are held stable, with no change of any kind.
- Selection:
  - RR=0: lowest-numbered pending line.
  - RR=1: first pending line scanning last+1, last+2, ... modulo 4.
  - The reset value last=3 makes the first RR grant match fixed priority.
- Capture: pending_next = (pending & ~clr) | (din & {4{en}}), where clr is the one-hot of s on load and 0 otherwise.
  - A request on the line being loaded in the same cycle stays pending and is served again later.
  - Requests on multiple lines in one cycle are all captured.
- en=0: din is ignored. Draining of pending lines and the output handshake continue unaffected.
- Merge: merge <= |(din & {4{en}} & pending & ~clr). It asserts for exactly one cycle per offending edge; the merged requests produce a single transfer.
- Latency: din sampled at edge t -> pending at t+1 -> valid with code at t+2, assuming the output is free. Throughput is one code per cycle with ready held high.
- busy = |pending | valid, combinational from registers.
- Fixed priority (RR=0) may starve high-numbered lines under continuous requests. This is intended; use RR=1 where fairness is required.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with din=4'hF, en=1, ready=1 -> valid=0, dout=00, busy=0, merge=0 throughout. Release with din=0 -> valid stays 0.
- Single request: din=4'b0100 for one cycle at edge t, ready=1 -> valid=1 with dout=2'b01 at t+2 for exactly one cycle; busy falls at t+3.
- Burst, RR=0: din=4'b1111 for one cycle, ready=1 -> dout 00, 10, 01, 11 on four consecutive cycles with valid=1; then valid=0 and busy=0.
- Backpressure: line 1 presented (dout=10, valid=1) with ready=0; pulse din=4'b0001 -> dout/valid hold 10 for the whole stall. On the first cycle with ready=1, 10 transfers; next cycle dout=00.
- Merge and enable: with ready=0 and line 3 pending, pulse din[3] again -> merge=1 for one cycle and only one 11 transfer ever occurs. din=4'hF with en=0 -> no pending change and no merge.
- Fairness: din=4'b0011 held and en=1, ready=1:
  - RR=0 -> dout=00 every cycle.
  - RR=1 -> dout alternates 00, 10, 00, 10.
  - Then assert rst_n=0 mid-stream -> valid=0 on the next edge, and no stale code appears after release with din=0.
